// File: rtl/cnn_decision_scheduler.sv
// cnn_decision_scheduler: shares one argmax comparator between two
// FC output engines, round-robin, and returns a tagged class result.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   src_req/valid     per-engine image request and score beat valid
//   src_data          packed scores, engine i at [DATA_W*i +: DATA_W]
//   src_gnt           registered one-hot grant, high only while loading
//   cmp_rst_n         comparator clear, active-low
//   cmp_valid_in/data registered score beat to the comparator
//   cmp_decision      comparator class index, qualified by cmp_valid_out
//   res_*             result handshake: id, class, timeout error flag
//   busy              scheduler not idle
module cnn_decision_scheduler #(
   parameter int NUM_CLASS = 10,
   parameter int DATA_W    = 12,
   parameter int TIMEOUT   = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          src_req,
   input  logic [1:0]          src_valid,
   input  logic [2*DATA_W-1:0] src_data,
   output logic [1:0]          src_gnt,
   output logic                cmp_rst_n,
   output logic                cmp_valid_in,
   output logic [DATA_W-1:0]   cmp_data_in,
   input  logic [3:0]          cmp_decision,
   input  logic                cmp_valid_out,
   output logic                res_valid,
   input  logic                res_ready,
   output logic                res_id,
   output logic [3:0]          res_class,
   output logic                res_err,
   output logic                busy
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [3:0] NCLS = 4'(NUM_CLASS);
   localparam logic [3:0] LAST_BEAT = 4'(NUM_CLASS - 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_CLR  = 3'd1;
   localparam logic [2:0] S_LOAD = 3'd2;
   localparam logic [2:0] S_WAIT = 3'd3;
   localparam logic [2:0] S_RESP = 3'd4;

   logic [2:0]        state;
   logic              id;
   logic              last_id;
   logic              clr_ph;
   logic [3:0]        beat_cnt;
   logic [TW-1:0]     tmo_cnt;
   logic              pick;
   logic              beat_ok;
   logic [DATA_W-1:0] sel_data;

   // A tie goes to the engine not served by the last tie.
   always_comb begin
      pick = src_req[1];
      if (&src_req) pick = ~last_id;
   end

   assign sel_data = id ? src_data[DATA_W +: DATA_W]
                        : src_data[0 +: DATA_W];

   // beat_cnt saturates at NUM_CLASS, so stray valids cannot wrap it.
   assign beat_ok = (state == S_LOAD) && src_valid[id]
                    && (beat_cnt < NCLS);

   assign busy = (state != S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         src_gnt      <= 2'b00;
         cmp_rst_n    <= 1'b0;
         cmp_valid_in <= 1'b0;
         cmp_data_in  <= '0;
         res_valid    <= 1'b0;
         res_id       <= 1'b0;
         res_class    <= 4'h0;
         res_err      <= 1'b0;
         id           <= 1'b0;
         last_id      <= 1'b1;
         clr_ph       <= 1'b0;
         beat_cnt     <= 4'h0;
         tmo_cnt      <= '0;
      end else begin
         cmp_valid_in <= beat_ok;
         if (beat_ok) cmp_data_in <= sel_data;

         case (state)
            S_IDLE: begin
               cmp_rst_n <= 1'b1;
               if (|src_req) begin
                  id        <= pick;
                  if (&src_req) last_id <= pick;
                  cmp_rst_n <= 1'b0;
                  clr_ph    <= 1'b0;
                  state     <= S_CLR;
               end
            end
            S_CLR: begin
               beat_cnt <= 4'h0;
               clr_ph   <= 1'b1;
               if (clr_ph) begin
                  cmp_rst_n <= 1'b1;
                  src_gnt   <= id ? 2'b10 : 2'b01;
                  state     <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (beat_ok) begin
                  beat_cnt <= beat_cnt + 4'd1;
                  if (beat_cnt == LAST_BEAT) begin
                     src_gnt <= 2'b00;
                     tmo_cnt <= '0;
                     state   <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               // A decision pulse beats a timeout in the same cycle.
               if (cmp_valid_out) begin
                  res_class <= cmp_decision;
                  res_err   <= 1'b0;
                  res_id    <= id;
                  res_valid <= 1'b1;
                  state     <= S_RESP;
               end else if (tmo_cnt == TMO_LAST) begin
                  res_class <= 4'hF;
                  res_err   <= 1'b1;
                  res_id    <= id;
                  res_valid <= 1'b1;
                  state     <= S_RESP;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            S_RESP: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cnn_decision_scheduler.sv
// tb_cnn_decision_scheduler: random image traffic, a behavioural
// argmax comparator and a transaction-level arbitration model.
module tb_cnn_decision_scheduler;

   localparam int NCLS = 10;
   localparam int DW   = 12;
   localparam int TMO  = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic [1:0]      src_req;
   logic [1:0]      src_valid;
   logic [2*DW-1:0] src_data;
   logic [1:0]      src_gnt;
   logic            cmp_rst_n;
   logic            cmp_valid_in;
   logic [DW-1:0]   cmp_data_in;
   logic [3:0]      cmp_decision;
   logic            cmp_valid_out;
   logic            res_valid;
   logic            res_ready;
   logic            res_id;
   logic [3:0]      res_class;
   logic            res_err;
   logic            busy;

   cnn_decision_scheduler #(
      .NUM_CLASS(NCLS),
      .DATA_W(DW),
      .TIMEOUT(TMO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .src_req(src_req),
      .src_valid(src_valid),
      .src_data(src_data),
      .src_gnt(src_gnt),
      .cmp_rst_n(cmp_rst_n),
      .cmp_valid_in(cmp_valid_in),
      .cmp_data_in(cmp_data_in),
      .cmp_decision(cmp_decision),
      .cmp_valid_out(cmp_valid_out),
      .res_valid(res_valid),
      .res_ready(res_ready),
      .res_id(res_id),
      .res_class(res_class),
      .res_err(res_err),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   logic signed [DW-1:0] fx [NCLS] = '{
      12'sd5, -12'sd3, 12'sd100, 12'sd7, 12'sd0,
      12'sd2, 12'sd1, 12'sd9, -12'sd50, 12'sd4};

   // comparator model state
   bit                   cm_never;
   bit                   cm_inject;
   int                   cm_dly;
   int                   cm_cd;
   int                   cm_cnt;
   int                   pulse_cyc;
   logic signed [DW-1:0] cm_best;
   logic [3:0]           cm_idx;

   // arbitration / monitor state
   bit            m_last;
   bit            m_cur_id;
   int            arb_cyc;
   int            first_fwd;
   int            last_fwd;
   logic [1:0]    prev_gnt;
   logic [1:0]    rh;
   bit            exp_gnt_q [$];
   bit            gnt_log [$];
   logic [DW-1:0] fwd_q [$];

   // Argmax comparator: first strict maximum wins, pulses after cm_dly.
   initial begin
      cmp_valid_out = 1'b0;
      cmp_decision  = 4'h0;
      cm_cnt = 0;
      cm_cd  = -1;
      forever begin
         @(negedge clk);
         cmp_valid_out = 1'b0;
         cmp_decision  = 4'($urandom);
         if (cm_inject) begin
            cmp_valid_out = 1'b1;
            cmp_decision  = 4'd7;
            cm_inject     = 1'b0;
         end else if (rst || !cmp_rst_n) begin
            cm_cnt = 0;
            cm_cd  = -1;
         end else begin
            if (cmp_valid_in) begin
               if (cm_cnt == 0 || $signed(cmp_data_in) > cm_best) begin
                  cm_best = $signed(cmp_data_in);
                  cm_idx  = 4'(cm_cnt);
               end
               cm_cnt++;
               if (cm_cnt == NCLS && !cm_never) cm_cd = cm_dly;
            end
            if (cm_cd == 0) begin
               cmp_valid_out = 1'b1;
               cmp_decision  = cm_idx;
               pulse_cyc     = cyc;
               cm_cd         = -1;
            end else if (cm_cd > 0) begin
               cm_cd--;
            end
         end
      end
   end

   // Monitor: arbitration model, grant timing, forwarded beats.
   initial begin
      prev_gnt = 2'b00;
      rh = 2'b00;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            prev_gnt = 2'b00;
            rh = 2'b00;
         end else begin
            if (!busy && |src_req) begin
               bit eid;
               arb_cyc = cyc;
               if (src_req == 2'b11) begin
                  eid = ~m_last;
                  m_last = eid;
               end else begin
                  eid = src_req[1];
               end
               exp_gnt_q.push_back(eid);
            end
            if (cmp_valid_in) begin
               fwd_q.push_back(cmp_data_in);
               if (fwd_q.size() == 1) first_fwd = cyc;
               last_fwd = cyc;
            end
            if (prev_gnt == 2'b00 && src_gnt != 2'b00) begin
               chk("gnt_expected", exp_gnt_q.size(), 1);
               if (exp_gnt_q.size() > 0) m_cur_id = exp_gnt_q.pop_front();
               chk("gnt_id", src_gnt, m_cur_id ? 2 : 1);
               chk("gnt_lat", cyc - arb_cyc, 3);
               chk("clr_pulse", {rh, cmp_rst_n}, 3'b001);
               gnt_log.push_back(src_gnt[1]);
            end
            prev_gnt = src_gnt;
            rh = {rh[0], cmp_rst_n};
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      src_req = 2'b00;
      src_valid = 2'b00;
      res_ready = 1'b0;
      repeat (3) @(negedge clk);
      m_last = 1'b1;
      exp_gnt_q.delete();
      gnt_log.delete();
      fwd_q.delete();
      rst = 1'b0;
   endtask

   task automatic run_image(input logic [1:0] req, input bit fixed,
                            input int gap, input bit never,
                            input bit hold, input int rst_beat,
                            input bit drop);
      logic signed [DW-1:0] sc [NCLS];
      logic signed [DW-1:0] best;
      logic [3:0]           ecls;
      logic [DW-1:0]        mine;
      logic [DW-1:0]        other;
      bit                   g;
      bit                   v;
      bit                   ov;
      int                   k;
      int                   n;
      int                   bad;
      src_req  = req;
      cm_never = never;
      cm_dly   = $urandom_range(0, 5);
      fwd_q.delete();
      for (int i = 0; i < NCLS; i++)
         sc[i] = fixed ? fx[i] : DW'($urandom);
      best = sc[0];
      ecls = 4'd0;
      for (int i = 1; i < NCLS; i++)
         if (sc[i] > best) begin
            best = sc[i];
            ecls = 4'(i);
         end
      if (never) ecls = 4'hF;

      n = 0;
      while (src_gnt == 2'b00 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("gnt_seen", {31'd0, |src_gnt}, 1);
      if (src_gnt == 2'b00) return;
      g = src_gnt[1];
      if (drop) src_req = 2'b00;

      k = 0;
      n = 0;
      while (k < NCLS && n < 300) begin
         if (gap == 0) v = 1'b1;
         else if (gap == 2) v = (n % 3 == 0);
         else v = ($urandom_range(0, 2) != 0);
         ov = (gap == 2) ? n[0] : 1'($urandom);
         mine  = v ? sc[k] : DW'($urandom);
         other = DW'($urandom);
         src_valid = g ? {v, ov} : {ov, v};
         src_data  = g ? {mine, other} : {other, mine};
         if (v && k == rst_beat - 1) begin
            @(posedge clk);
            #2;
            rst = 1'b1;
            #1;
            chk("arst_gnt", src_gnt, 0);
            chk("arst_cmp_rst_n", cmp_rst_n, 0);
            chk("arst_busy", busy, 0);
            chk("arst_vin", cmp_valid_in, 0);
            @(negedge clk);
            src_valid = 2'b00;
            src_req = 2'b00;
            @(negedge clk);
            m_last = 1'b1;
            exp_gnt_q.delete();
            fwd_q.delete();
            rst = 1'b0;
            return;
         end
         @(negedge clk);
         n++;
         if (v) k++;
      end
      src_valid = 2'b00;
      chk("beats_in", k, NCLS);
      chk("gnt_drop", src_gnt, 0);

      n = 0;
      while (!res_valid && n < TMO + 20) begin
         @(negedge clk);
         n++;
      end
      chk("res_seen", res_valid, 1);
      if (!res_valid) return;
      if (never) chk("tmo_lat", cyc - last_fwd, TMO);
      else chk("res_lat", cyc - pulse_cyc, 1);
      chk("res_id", res_id, m_cur_id);
      chk("res_class", res_class, ecls);
      chk("res_err", res_err, never);
      chk("fwd_n", fwd_q.size(), NCLS);
      bad = 0;
      for (int i = 0; i < NCLS && i < fwd_q.size(); i++)
         if (fwd_q[i] !== sc[i]) bad++;
      chk("fwd_data", bad, 0);

      if (hold) begin
         bad = 0;
         for (int i = 0; i < 20; i++) begin
            if (i == 8) cm_inject = 1'b1;
            @(negedge clk);
            if (res_valid !== 1'b1 || res_id !== m_cur_id ||
                res_class !== ecls || res_err !== never ||
                src_gnt !== 2'b00 || busy !== 1'b1) bad++;
         end
         chk("resp_hold", bad, 0);
      end else begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("acc_valid", res_valid, 0);
      chk("acc_idle", busy, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      src_req = 2'b00;
      src_valid = 2'b00;
      src_data = '0;
      res_ready = 1'b0;
      cm_never = 1'b0;
      cm_inject = 1'b0;
      cm_dly = 0;
      m_last = 1'b1;
      #2;
      chk("rst_gnt", src_gnt, 0);
      chk("rst_cmp_rst_n", cmp_rst_n, 0);
      chk("rst_vin", cmp_valid_in, 0);
      chk("rst_din", cmp_data_in, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_id", res_id, 0);
      chk("rst_res_class", res_class, 0);
      chk("rst_res_err", res_err, 0);
      chk("rst_busy", busy, 0);
      do_reset();
      @(negedge clk);
      @(negedge clk);
      chk("idle_cmp_rst_n", cmp_rst_n, 1);
      chk("idle_busy", busy, 0);

      // engine 0 alone, fixed scores, gap-free, request dropped
      run_image(2'b01, 1'b1, 0, 1'b0, 1'b0, 0, 1'b1);
      chk("a_burst", last_fwd - first_fwd, 9);

      // both requesting from reset: 0,1,0,1
      do_reset();
      repeat (4) run_image(2'b11, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
      chk("b_count", gnt_log.size(), 4);
      if (gnt_log.size() == 4)
         for (int i = 0; i < 4; i++)
            chk("b_order", gnt_log[i], i % 2);

      // engine 1 with 1,0,0 gaps, engine 0 toggling valid
      run_image(2'b10, 1'b0, 2, 1'b0, 1'b0, 0, 1'b0);
      // comparator never answers
      run_image(2'b01, 1'b0, 0, 1'b1, 1'b0, 0, 1'b0);
      // result back-pressured, stray decision pulse in RESP
      run_image(2'b10, 1'b0, 1, 1'b0, 1'b1, 0, 1'b0);
      // async reset on the 5th beat, then a clean image
      run_image(2'b01, 1'b0, 0, 1'b0, 1'b0, 5, 1'b0);
      run_image(2'b01, 1'b0, 1, 1'b0, 1'b0, 0, 1'b0);

      repeat (16) begin
         logic [1:0] rq;
         rq = 2'($urandom_range(1, 3));
         run_image(rq, 1'b0, 1, ($urandom_range(0, 7) == 0),
                   1'b0, 0, 1'b0);
      end

      src_req = 2'b00;
      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule
